// File: rtl/dut_reduce_fifo_if.sv
// -----------------------------------------------------------------------------
// dut_reduce_fifo_if
//   Address-mapped write/read bus of the reduce FIFO block.
//   Ports (by direction on the slave side):
//     write_address [2:0]   in   write target
//     write_data    [W-1:0] in   write payload
//     write_en              in   write request
//     write_rdy             out  write target can accept
//     read_address  [2:0]   in   read source
//     read_en               in   read request
//     read_data     [W-1:0] out  registered read result
//     read_rdy              out  read source can supply
//   Modports: master (bus driver), slave (the block).
// -----------------------------------------------------------------------------
interface dut_reduce_fifo_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       write_address;
  logic [WIDTH-1:0] write_data;
  logic             write_en;
  logic             write_rdy;
  logic [2:0]       read_address;
  logic             read_en;
  logic [WIDTH-1:0] read_data;
  logic             read_rdy;

  modport master (
    output write_address, write_data, write_en, read_address, read_en,
    input  write_rdy, read_data, read_rdy
  );

  modport slave (
    input  write_address, write_data, write_en, read_address, read_en,
    output write_rdy, read_data, read_rdy
  );
endinterface

// File: rtl/dut_reduce_fifo.sv
// -----------------------------------------------------------------------------
// dut_reduce_fifo
//   NCH input channels, each with its own WIDTH-bit FIFO, are popped together
//   whenever all hold data and the result FIFO has room. The channel heads are
//   combined by a runtime-selectable op (OR/AND/XOR/ADD) and pushed into the
//   result FIFO, one result per cycle.
//
//   Write map: 3 = op register, 4+i (i<NCH) = push channel i, others discarded.
//   Read map : 0 = channel not-full flags, 1 = result not-empty, 2 = pop result,
//              3 = op register, 4 = result occupancy, 5 = compute counter,
//              6/7 = 0.
//
//   Ports:
//     CLK    in  clock, all state on rising edge
//     RST_N  in  asynchronous active-low reset
//     bus    slave modport of dut_reduce_fifo_if
//
//   Optional feature: define DUT_REDUCE_RESCNT_EN to add an 8-bit saturating
//   compute counter readable (and cleared) at read address 5. Without it,
//   address 5 reads 0 and no counter logic exists.
// -----------------------------------------------------------------------------
module dut_reduce_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NCH   = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  dut_reduce_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_ADD = 2'd3
  } op_e;

  op_e op_q;

  // Channel FIFOs. Pointers carry one extra wrap bit so full and empty differ.
  logic [WIDTH-1:0] ch_mem    [NCH][DEPTH];
  logic [AW:0]      ch_wr_ptr [NCH];
  logic [AW:0]      ch_rd_ptr [NCH];
  logic [WIDTH-1:0] ch_head   [NCH];
  logic [NCH-1:0]   ch_full;
  logic [NCH-1:0]   ch_empty;
  logic [NCH-1:0]   ch_push;

  // Result FIFO.
  logic [WIDTH-1:0] res_mem [DEPTH];
  logic [AW:0]      res_wr_ptr;
  logic [AW:0]      res_rd_ptr;
  logic [AW:0]      res_count;
  logic             res_full;
  logic             res_empty;
  logic             res_pop;

  logic             write_fire;
  logic             read_fire;
  logic             compute;
  logic [WIDTH-1:0] reduced;
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] read_data_q;

`ifdef DUT_REDUCE_RESCNT_EN
  logic [7:0] res_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Status flags and handshakes
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    ch_full   = '0;
    ch_empty  = '0;
    bus.write_rdy = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      ch_empty[i] = (ch_wr_ptr[i] == ch_rd_ptr[i]);
      ch_full[i]  = (ch_wr_ptr[i][AW] != ch_rd_ptr[i][AW]) &&
                    (ch_wr_ptr[i][AW-1:0] == ch_rd_ptr[i][AW-1:0]);
      ch_head[i]  = ch_mem[i][ch_rd_ptr[i][AW-1:0]];
      // Registered full only: a pop in the same cycle does not free the slot.
      if (bus.write_address == 3'(4 + i) && ch_full[i]) bus.write_rdy = 1'b0;
    end
  end

  assign res_count = res_wr_ptr - res_rd_ptr;
  assign res_empty = (res_wr_ptr == res_rd_ptr);
  assign res_full  = (res_wr_ptr[AW] != res_rd_ptr[AW]) &&
                     (res_wr_ptr[AW-1:0] == res_rd_ptr[AW-1:0]);

  assign bus.read_rdy = !(bus.read_address == 3'd2 && res_empty);
  assign write_fire   = bus.write_en && bus.write_rdy;
  assign read_fire    = bus.read_en && bus.read_rdy;
  assign res_pop      = read_fire && (bus.read_address == 3'd2);
  assign compute      = !(|ch_empty) && !res_full;

  always_comb begin
    ch_push = '0;
    for (int i = 0; i < NCH; i++)
      ch_push[i] = write_fire && (bus.write_address == 3'(4 + i));
  end

  // ---------------------------------------------------------------------------
  // Reduction of the channel heads with the currently registered op
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so each iteration sees the
    // partial result of the previous one.
    reduced = ch_head[0];
    for (int i = 1; i < NCH; i++) begin
      case (op_q)
        OP_OR:   reduced = reduced | ch_head[i];
        OP_AND:  reduced = reduced & ch_head[i];
        OP_XOR:  reduced = reduced ^ ch_head[i];
        default: reduced = reduced + ch_head[i];  // carries out of WIDTH dropped
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read source multiplexer (value captured into read_data on accepted read)
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (bus.read_address)
      3'd0: rd_mux[NCH-1:0] = ~ch_full;
      3'd1: rd_mux[0]       = !res_empty;
      3'd2: rd_mux          = res_mem[res_rd_ptr[AW-1:0]];
      3'd3: rd_mux[1:0]     = op_q;
      3'd4: rd_mux[AW:0]    = res_count;
`ifdef DUT_REDUCE_RESCNT_EN
      3'd5: rd_mux[7:0]     = res_cnt;
`endif
      default: rd_mux = '0;
    endcase
  end

  assign bus.read_data = read_data_q;

  // ---------------------------------------------------------------------------
  // Storage arrays
  // ---------------------------------------------------------------------------
  // NOTE: the data arrays have no reset; validity is tracked by the pointers,
  // which are reset, so clearing the payload would only cost flops.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++)
      if (ch_push[i]) ch_mem[i][ch_wr_ptr[i][AW-1:0]] <= bus.write_data;
    if (compute) res_mem[res_wr_ptr[AW-1:0]] <= reduced;
  end

  // ---------------------------------------------------------------------------
  // Pointers, op register and read data
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NCH; i++) begin
        ch_wr_ptr[i] <= '0;
        ch_rd_ptr[i] <= '0;
      end
      res_wr_ptr  <= '0;
      res_rd_ptr  <= '0;
      op_q        <= OP_OR;
      read_data_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_push[i]) ch_wr_ptr[i] <= ch_wr_ptr[i] + 1'b1;
        if (compute)    ch_rd_ptr[i] <= ch_rd_ptr[i] + 1'b1;
      end
      if (compute)   res_wr_ptr  <= res_wr_ptr + 1'b1;
      if (res_pop)   res_rd_ptr  <= res_rd_ptr + 1'b1;
      if (write_fire && bus.write_address == 3'd3)
        op_q <= op_e'(bus.write_data[1:0]);
      if (read_fire) read_data_q <= rd_mux;
    end
  end

`ifdef DUT_REDUCE_RESCNT_EN
  // Saturating compute counter; a read of address 5 clears it, but a compute
  // on that same edge is still counted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_cnt <= '0;
    end else if (read_fire && bus.read_address == 3'd5) begin
      res_cnt <= compute ? 8'd1 : 8'd0;
    end else if (compute && res_cnt != 8'hFF) begin
      res_cnt <= res_cnt + 8'd1;
    end
  end
`endif

endmodule
